uart_rx_param: RTL and testbench

Parametrised asynchronous serial receiver and successor to the fixed 8N1 receiver. It supports configurable data width, parity, stop bits and oversampling ratio, and reports parity, framing and break errors. Idle and end-of-packet detection are retained with a configurable gap length. It sits between the board RxD pin and the command/packet parser.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_rx_param.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver and its baud tick generator.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // round(baud * oversample * 2^acc_width / clk_freq), evaluated in 64 bits
  function automatic longint unsigned calc_inc(input longint unsigned clk_freq,
                                               input longint unsigned baud,
                                               input longint unsigned oversample,
                                               input int unsigned     acc_width);
    longint unsigned num;
    num = (baud * oversample) << acc_width;
    return (64'd2 * num + clk_freq) / (64'd2 * clk_freq);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional accumulator producing one-cycle oversampling ticks; shared with the transmitter.
module uart_baud_tick
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 32000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned ACC_WIDTH  = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  typedef logic [ACC_WIDTH:0] acc_ext_t;

  localparam longint unsigned IncVal = calc_inc(64'(CLK_FREQ), 64'(BAUD), 64'(OVERSAMPLE),
                                                ACC_WIDTH);
  // One bit wider than the accumulator so INC == 2^ACC_WIDTH (tick every clk) is representable
  localparam acc_ext_t Inc = acc_ext_t'(IncVal);

  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_tick;
  acc_ext_t             w_sum;

  assign w_sum  = {1'b0, r_acc} + Inc;
  assign o_tick = r_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_acc  <= w_sum[ACC_WIDTH-1:0];
      r_tick <= w_sum[ACC_WIDTH];
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with parity/framing/break detection and idle/end-of-packet flags.
// Optional output FIFO enabled by defining UART_RX_FIFO_EN.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 32000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned GAP_BITS   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_break,
  output logic                 o_rx_idle,
  output logic                 o_rx_eop,
  output logic                 o_rx_overflow
);

  localparam int unsigned    CntW      = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] CntMid   = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntEnd   = CntW'(OVERSAMPLE - 1);
  localparam int unsigned    GapMax    = GAP_BITS * OVERSAMPLE;
  localparam int unsigned    GapW      = $clog2(GapMax + 1);
  localparam logic [GapW-1:0] GapSat   = GapW'(GapMax);
  localparam logic [3:0]     BitLast   = 4'(DATA_BITS - 1);
  localparam logic           StopLast  = 1'(STOP_BITS - 1);
  localparam logic           HasParity = (PARITY != PAR_NONE);
  localparam logic           ParTarget = (PARITY == PAR_ODD);

  logic w_tick;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_baud_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_tick(w_tick)
  );

  // Synchroniser and majority filter preset high so reset never looks like a start bit
  logic [1:0] r_sync;
  logic [2:0] r_filt;
  logic       w_filt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b11;
      r_filt <= 3'b111;
    end else begin
      r_sync <= {r_sync[0], i_rxd};
      if (w_tick) r_filt <= {r_filt[1:0], r_sync[1]};
    end
  end

  assign w_filt = (r_filt[0] & r_filt[1]) | (r_filt[0] & r_filt[2]) | (r_filt[1] & r_filt[2]);

  rx_state_e            r_state, w_state_nxt;
  logic [CntW-1:0]      r_tick_cnt, w_tick_cnt_nxt;
  logic [3:0]           r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_stop_cnt, w_stop_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par_bit, w_par_bit_nxt;
  logic                 r_stop_first, w_stop_first_nxt;
  logic                 r_stop_any, w_stop_any_nxt;
  logic                 w_done, w_frame, w_brk, w_par_err;
  logic                 w_any_low, w_first_low;

  assign w_par_err = HasParity & ((^r_shift ^ r_par_bit) != ParTarget);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_stop_first <= 1'b0;
      r_stop_any   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_stop_cnt   <= w_stop_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_par_bit    <= w_par_bit_nxt;
      r_stop_first <= w_stop_first_nxt;
      r_stop_any   <= w_stop_any_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_tick_cnt_nxt   = r_tick_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_stop_cnt_nxt   = r_stop_cnt;
    w_shift_nxt      = r_shift;
    w_par_bit_nxt    = r_par_bit;
    w_stop_first_nxt = r_stop_first;
    w_stop_any_nxt   = r_stop_any;
    w_done           = 1'b0;
    w_frame          = 1'b0;
    w_brk            = 1'b0;
    w_any_low        = r_stop_any | ~w_filt;
    w_first_low      = (r_stop_cnt == 1'b0) ? ~w_filt : r_stop_first;
    if (w_tick) begin
      unique case (r_state)
        StIdle: begin
          if (!w_filt) begin
            w_state_nxt    = StStart;
            w_tick_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
          end
        end
        StStart: begin
          if (r_tick_cnt == CntMid) begin
            w_tick_cnt_nxt = '0;
            w_state_nxt    = w_filt ? StIdle : StData;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + CntW'(1);
          end
        end
        StData: begin
          if (r_tick_cnt == CntEnd) begin
            w_tick_cnt_nxt = '0;
            w_shift_nxt    = {w_filt, r_shift[DATA_BITS-1:1]};
            w_bit_cnt_nxt  = r_bit_cnt + 4'd1;
            if (r_bit_cnt == BitLast) begin
              w_bit_cnt_nxt    = '0;
              w_stop_cnt_nxt   = 1'b0;
              w_stop_first_nxt = 1'b0;
              w_stop_any_nxt   = 1'b0;
              w_state_nxt      = HasParity ? StParity : StStop;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + CntW'(1);
          end
        end
        StParity: begin
          if (r_tick_cnt == CntEnd) begin
            w_tick_cnt_nxt = '0;
            w_par_bit_nxt  = w_filt;
            w_state_nxt    = StStop;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + CntW'(1);
          end
        end
        StStop: begin
          if (r_tick_cnt == CntEnd) begin
            w_tick_cnt_nxt   = '0;
            w_stop_any_nxt   = w_any_low;
            w_stop_first_nxt = w_first_low;
            if (r_stop_cnt == StopLast) begin
              if (!w_any_low) begin
                w_done      = 1'b1;
                w_state_nxt = StIdle;
              end else if ((r_shift == '0) && !(HasParity && r_par_bit) && w_first_low) begin
                w_brk       = 1'b1;
                w_state_nxt = StWaitHigh;
              end else begin
                w_frame     = 1'b1;
                w_state_nxt = StWaitHigh;
              end
            end else begin
              w_stop_cnt_nxt = 1'b1;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + CntW'(1);
          end
        end
        StWaitHigh: begin
          if (w_filt) w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // Registered result strobes: one clk after the final stop sample tick
  logic                 r_out_valid, r_out_perr, r_out_frame, r_out_break;
  logic [DATA_BITS-1:0] r_out_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_perr  <= 1'b0;
      r_out_frame <= 1'b0;
      r_out_break <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_done;
      r_out_perr  <= w_done & w_par_err;
      r_out_frame <= w_frame;
      r_out_break <= w_brk;
      if (w_done | w_frame | w_brk) r_out_data <= r_shift;
    end
  end

  assign o_rx_frame_err = r_out_frame;
  assign o_rx_break     = r_out_break;

  logic [GapW-1:0] r_gap;
  logic            r_idle_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gap       <= '0;
      r_idle_prev <= 1'b0;
    end else begin
      r_idle_prev <= o_rx_idle;
      if (w_state_nxt != StIdle)             r_gap <= '0;
      else if (w_tick && (r_gap != GapSat))  r_gap <= r_gap + GapW'(1);
    end
  end

  assign o_rx_idle = (r_gap == GapSat);
  assign o_rx_eop  = o_rx_idle & ~r_idle_prev;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS:0] r_mem [FIFO_DEPTH];
  logic [PtrW:0]      r_wr_ptr, r_rd_ptr;
  logic               r_ovf;
  logic               w_empty, w_full, w_pop, w_push_ok;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                     (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
  assign w_pop     = ~w_empty & i_rx_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign w_push_ok = r_out_valid & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[PtrW-1:0]] <= {r_out_perr, r_out_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok)                r_wr_ptr <= r_wr_ptr + (PtrW + 1)'(1);
      if (w_pop)                    r_rd_ptr <= r_rd_ptr + (PtrW + 1)'(1);
      if (r_out_valid & ~w_push_ok) r_ovf    <= 1'b1;
    end
  end

  assign o_rx_valid      = ~w_empty;
  assign o_rx_data       = w_empty ? '0 : r_mem[r_rd_ptr[PtrW-1:0]][DATA_BITS-1:0];
  assign o_rx_parity_err = ~w_empty & r_mem[r_rd_ptr[PtrW-1:0]][DATA_BITS];
  assign o_rx_overflow   = r_ovf;
`else
  logic w_unused_ready;

  assign w_unused_ready  = i_rx_ready;
  assign o_rx_valid      = r_out_valid;
  assign o_rx_data       = r_out_data;
  assign o_rx_parity_err = r_out_perr;
  assign o_rx_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and a 7E1 instance at 16 clk per bit.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd8, rxd7, ready8, ready7;
  logic [7:0] d8;
  logic [6:0] d7;
  logic       v8, pe8, fe8, brk8, idle8, eop8, ovf8;
  logic       v7, pe7, fe7, brk7, idle7, eop7, ovf7;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ(1843200), .BAUD(115200), .OVERSAMPLE(16), .ACC_WIDTH(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .GAP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_rxd(rxd8), .o_rx_data(d8), .o_rx_valid(v8),
    .i_rx_ready(ready8), .o_rx_parity_err(pe8), .o_rx_frame_err(fe8), .o_rx_break(brk8),
    .o_rx_idle(idle8), .o_rx_eop(eop8), .o_rx_overflow(ovf8)
  );

  uart_rx_param #(
    .CLK_FREQ(1843200), .BAUD(115200), .OVERSAMPLE(16), .ACC_WIDTH(16),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .GAP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut7 (
    .i_clk(clk), .i_rst(rst), .i_rxd(rxd7), .o_rx_data(d7), .o_rx_valid(v7),
    .i_rx_ready(ready7), .o_rx_parity_err(pe7), .o_rx_frame_err(fe7), .o_rx_break(brk7),
    .o_rx_idle(idle7), .o_rx_eop(eop7), .o_rx_overflow(ovf7)
  );

  int n_vec = 0;
  int n_err = 0;

  // Event counters sampled on the falling edge
  int         n_valid8 = 0, n_frame8 = 0, n_break8 = 0, n_eop8 = 0, n_excl = 0;
  int         n_valid7 = 0;
  logic [7:0] last_data8 = '0, fe_data8 = '0;
  logic       last_perr8 = 1'b0, last_perr7 = 1'b0;
  logic [6:0] last_data7 = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (v8) begin n_valid8++; last_data8 = d8; last_perr8 = pe8; end
      if (fe8) begin n_frame8++; fe_data8 = d8; end
      if (brk8) n_break8++;
      if (eop8) n_eop8++;
      if ((v8 & fe8) | (v8 & brk8) | (fe8 & brk8) | (v7 & fe7) | (v7 & brk7) | (fe7 & brk7))
        n_excl++;
      if (v7) begin n_valid7++; last_data7 = d7; last_perr7 = pe7; end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input int sel, input logic b);
    if (sel == 8) rxd8 = b;
    else          rxd7 = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic idle_bits(input int sel, input int n);
    for (int i = 0; i < n; i++) send_bit(sel, 1'b1);
  endtask

  // par < 0 means no parity bit
  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits, input int par,
                            input logic stop);
    send_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(sel, data[i]);
    if (par >= 0) send_bit(sel, (par != 0));
    send_bit(sel, stop);
  endtask

  int b_v, b_f, b_b, b_e, b_v7;

  initial begin
    rst = 1'b1; rxd8 = 1'b1; rxd7 = 1'b1; ready8 = 1'b1; ready7 = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_valid", {31'd0, v8}, 0);
    check("rst_data", {24'd0, d8}, 0);
    check("rst_flags", {28'd0, pe8, fe8, brk8, ovf8}, 0);
    check("rst_idle_eop", {28'd0, idle8, eop8, idle7, eop7}, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_after_reset", {31'd0, idle8}, 1);
    check("eop_after_reset", n_eop8, 1);

    // 8N1 0xA5
    b_v = n_valid8; b_f = n_frame8; b_b = n_break8; b_e = n_eop8;
    send_frame(8, 9'h0A5, 8, -1, 1'b1);
    check("idle_low_after_frame", {31'd0, idle8}, 0);
    idle_bits(8, 3);
    check("a5_valid_cnt", n_valid8 - b_v, 1);
    check("a5_data", {24'd0, last_data8}, 32'hA5);
    check("a5_perr", {31'd0, last_perr8}, 0);
    check("a5_no_err", (n_frame8 - b_f) + (n_break8 - b_b), 0);
    check("a5_idle", {31'd0, idle8}, 1);
    check("a5_eop_cnt", n_eop8 - b_e, 1);

    // 7E1 0x41 good and bad parity
    b_v7 = n_valid7;
    send_frame(7, 9'h041, 7, 0, 1'b1);
    idle_bits(7, 2);
    check("e7_valid_cnt", n_valid7 - b_v7, 1);
    check("e7_data", {25'd0, last_data7}, 32'h41);
    check("e7_perr_ok", {31'd0, last_perr7}, 0);
    send_frame(7, 9'h041, 7, 1, 1'b1);
    idle_bits(7, 2);
    check("e7_valid_cnt2", n_valid7 - b_v7, 2);
    check("e7_data2", {25'd0, last_data7}, 32'h41);
    check("e7_perr_bad", {31'd0, last_perr7}, 1);

    // 3-clk glitch
    b_v = n_valid8; b_f = n_frame8; b_b = n_break8;
    rxd8 = 1'b0;
    repeat (3) @(negedge clk);
    rxd8 = 1'b1;
    repeat (48) @(negedge clk);
    check("glitch_valid", n_valid8 - b_v, 0);
    check("glitch_frame", n_frame8 - b_f, 0);
    check("glitch_break", n_break8 - b_b, 0);

    // Framing error then a good frame
    b_v = n_valid8; b_f = n_frame8; b_b = n_break8;
    send_frame(8, 9'h03C, 8, -1, 1'b0);
    idle_bits(8, 2);
    check("fe_cnt", n_frame8 - b_f, 1);
    check("fe_no_valid", n_valid8 - b_v, 0);
    check("fe_no_break", n_break8 - b_b, 0);
`ifndef UART_RX_FIFO_EN
    check("fe_data", {24'd0, fe_data8}, 32'h3C);
`endif
    send_frame(8, 9'h055, 8, -1, 1'b1);
    idle_bits(8, 3);
    check("after_fe_valid", n_valid8 - b_v, 1);
    check("after_fe_data", {24'd0, last_data8}, 32'h55);

    // Break: 40 bit-times low
    b_v = n_valid8; b_f = n_frame8; b_b = n_break8;
    rxd8 = 1'b0;
    repeat (640) @(negedge clk);
    check("brk_cnt", n_break8 - b_b, 1);
    check("brk_no_frame", n_frame8 - b_f, 0);
    check("brk_no_valid", n_valid8 - b_v, 0);
    idle_bits(8, 2);
    send_frame(8, 9'h012, 8, -1, 1'b1);
    idle_bits(8, 3);
    check("brk_cnt_after", n_break8 - b_b, 1);
    check("after_brk_valid", n_valid8 - b_v, 1);
    check("after_brk_data", {24'd0, last_data8}, 32'h12);

    check("flags_exclusive", n_excl, 0);
    check("no_overflow", {30'd0, ovf8, ovf7}, 0);

`ifdef UART_RX_FIFO_EN
    ready8 = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      send_frame(8, 9'(b), 8, -1, 1'b1);
      idle_bits(8, 1);
    end
    idle_bits(8, 1);
    check("fifo_overflow", {31'd0, ovf8}, 1);
    for (int i = 1; i <= 4; i++) begin
      check("fifo_valid", {31'd0, v8}, 1);
      check("fifo_data", {24'd0, d8}, 32'(i));
      ready8 = 1'b1;
      @(negedge clk);
      ready8 = 1'b0;
    end
    check("fifo_empty", {31'd0, v8}, 0);
    ready8 = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
